// File: rtl/acq_readout_pkg.sv
// Shared types and helpers for the acquisition readout block: FSM states,
// segment-mode encodings and per-mode segment geometry.
package acq_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SEG_CONTINUOUS = 2'd0;
    localparam logic [1:0] SEG_LONG       = 2'd1;
    localparam logic [1:0] SEG_SHORT      = 2'd2;
    localparam logic [1:0] SEG_SHORT_ALT  = 2'd3;

    typedef struct packed {
        logic [31:0] seg_words;
        logic [31:0] seg_count;
    } seg_geom_t;

    function automatic int adc_shift(input int sample_w, input int adc_w);
        return sample_w - adc_w;
    endfunction

    localparam int ADC_SHIFT = adc_shift(16, 14);

    // Words per segment and segment count; their product is always the RAM depth.
    function automatic seg_geom_t seg_geometry(input logic [1:0] mode, input int capacity,
                                               input int long_cap, input int short_cap,
                                               input int spc);
        seg_geom_t g;
        case (mode)
            SEG_CONTINUOUS: begin
                g.seg_words = 32'(capacity / spc);
                g.seg_count = 32'd1;
            end
            SEG_LONG: begin
                g.seg_words = 32'(long_cap / spc);
                g.seg_count = 32'(capacity / long_cap);
            end
            default: begin
                g.seg_words = 32'(short_cap / spc);
                g.seg_count = 32'(capacity / short_cap);
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/acquisition_readout_if.sv
// AXI4-Stream sample channel between the readout block and its consumer.
interface acquisition_readout_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/acq_readout_word_fifo.sv
// Small synchronous word FIFO with occupancy count and flush; holds RAM words
// between the read pipeline and the sample serializer.
module acq_readout_word_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count_reg != CW'(DEPTH));
    assign do_pop    = pop && (count_reg != '0);
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/acquisition_readout.sv
// Reads a completed capture from the acquisition DPRAM in time order and streams it as AXI4-Stream samples.
// Define ACQ_READOUT_TIMESTAMP_HEADER_EN to prefix each readout with the trigger timestamp beats.
module acquisition_readout
    import acq_readout_pkg::*;
#(
    parameter int ACQUISITION_BUFFER_CAPACITY = 16384,
    parameter int AXI_SAMPLES_PER_CLOCK       = 4,
    parameter int AXI_SAMPLE_WIDTH            = 16,
    parameter int ADC_WIDTH                   = 14,
    parameter int LONG_SEGMENT_CAPACITY       = 2048,
    parameter int SHORT_SEGMENT_CAPACITY      = 512,
    parameter int TRIGGER_DETECTION_LATENCY   = 4,
    parameter int RAM_READ_LATENCY            = 2,
    parameter int ADC_RAM_ADDRESS_WIDTH       = $clog2(ACQUISITION_BUFFER_CAPACITY / AXI_SAMPLES_PER_CLOCK)
) (
    input  logic                                        sysClk,
    input  logic                                        sysReset_n,
    input  logic                                        start,
    input  logic                                        abort,
    input  logic [1:0]                                  segMode,
    input  logic [ADC_RAM_ADDRESS_WIDTH-1:0]            pretriggerCount,
    input  logic [ADC_RAM_ADDRESS_WIDTH-1:0]            triggerAddress,
    input  logic [63:0]                                 triggerTimestamp,
    output logic [ADC_RAM_ADDRESS_WIDTH-1:0]            ramRdAddr,
    input  logic [AXI_SAMPLES_PER_CLOCK*ADC_WIDTH-1:0]  ramRdData,
    acquisition_readout_if.master                       m,
    output logic                                        busy,
    output logic                                        done
);
    localparam int AW         = ADC_RAM_ADDRESS_WIDTH;
    localparam int SPC        = AXI_SAMPLES_PER_CLOCK;
    localparam int WORD_W     = SPC * ADC_WIDTH;
    localparam int SHIFT      = adc_shift(AXI_SAMPLE_WIDTH, ADC_WIDTH);
    localparam int FIFO_DEPTH = RAM_READ_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int SCW        = $clog2(ACQUISITION_BUFFER_CAPACITY + 1);
    localparam int IDXW       = (SPC > 1) ? $clog2(SPC) : 1;

    state_t                  state_reg, state_next;
    seg_geom_t               geom;
    logic [AW-1:0]           rd_addr_reg;
    logic [AW:0]             reads_left_reg;
    logic [RAM_READ_LATENCY-1:0] tag_reg;
    logic [SCW-1:0]          seg_last_idx_reg, seg_pos_reg, sent_reg;
    logic [IDXW-1:0]         lane_reg;
    logic [AXI_SAMPLE_WIDTH-1:0] tdata_reg, sample_ext;
    logic                    tvalid_reg, tlast_reg, final_reg;
    logic [WORD_W-1:0]       fifo_head;
    logic [CW-1:0]           fifo_count, inflight;
    logic [ADC_WIDTH-1:0]    lane_sample [SPC];
    logic                    start_accept, issue, handshake, out_free, load_sample, pop;

    genvar gi;
    generate
        for (gi = 0; gi < SPC; gi++) begin : g_lane
            assign lane_sample[gi] = fifo_head[gi*ADC_WIDTH +: ADC_WIDTH];
        end
    endgenerate

    assign geom         = seg_geometry(segMode, ACQUISITION_BUFFER_CAPACITY, LONG_SEGMENT_CAPACITY,
                                       SHORT_SEGMENT_CAPACITY, SPC);
    assign start_accept = start && !abort && (state_reg == ST_IDLE);
    assign handshake    = tvalid_reg && m.tready;
    assign out_free     = !tvalid_reg || m.tready;
    assign load_sample  = (state_reg == ST_STREAM) && out_free && (fifo_count != '0) && !abort;
    assign pop          = load_sample && (lane_reg == IDXW'(SPC - 1));
    assign sample_ext   = AXI_SAMPLE_WIDTH'(lane_sample[lane_reg]) << SHIFT;

    // A read may only be issued if its word is guaranteed a FIFO slot on return.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_READ_LATENCY; i++) begin
            inflight = inflight + CW'(tag_reg[i]);
        end
        issue = ((state_reg == ST_STREAM) || (state_reg == ST_HEADER)) && !abort &&
                (reads_left_reg != '0) && ((CW'(FIFO_DEPTH) - fifo_count) > inflight);
    end

    acq_readout_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk       (sysClk),
        .rst_n     (sysReset_n),
        .flush     (abort),
        .push      (tag_reg[RAM_READ_LATENCY-1]),
        .push_data (ramRdData),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

`ifdef ACQ_READOUT_TIMESTAMP_HEADER_EN
    localparam int HDR_BEATS = 64 / AXI_SAMPLE_WIDTH;
    localparam int HCW       = $clog2(HDR_BEATS + 1);
    localparam int HIW       = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

    logic [63:0]                 ts_reg;
    logic [HCW-1:0]              hdr_cnt_reg;
    logic [AXI_SAMPLE_WIDTH-1:0] hdr_chunk [HDR_BEATS];
    logic                        load_hdr;

    generate
        for (gi = 0; gi < HDR_BEATS; gi++) begin : g_hdr
            assign hdr_chunk[gi] = ts_reg[(HDR_BEATS-1-gi)*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH];
        end
    endgenerate

    assign load_hdr = (state_reg == ST_HEADER) && out_free && !abort && (hdr_cnt_reg < HCW'(HDR_BEATS));

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            ts_reg      <= '0;
            hdr_cnt_reg <= '0;
        end else if (abort) begin
            hdr_cnt_reg <= '0;
        end else if (start_accept) begin
            ts_reg      <= triggerTimestamp;
            hdr_cnt_reg <= '0;
        end else if (load_hdr) begin
            hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_timestamp;
    assign unused_timestamp = ^triggerTimestamp;
`endif

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) state_reg <= ST_IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
`ifdef ACQ_READOUT_TIMESTAMP_HEADER_EN
                ST_IDLE:   if (start) state_next = ST_HEADER;
                ST_HEADER: if (hdr_cnt_reg == HCW'(HDR_BEATS)) state_next = ST_STREAM;
`else
                ST_IDLE:   if (start) state_next = ST_STREAM;
                ST_HEADER: state_next = ST_STREAM;
`endif
                ST_STREAM: if (handshake && final_reg) state_next = ST_DONE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg == ST_HEADER) || (state_reg == ST_STREAM);
        done = (state_reg == ST_DONE);
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            tag_reg <= '0;
        end else if (abort) begin
            tag_reg <= '0;
        end else begin
            tag_reg[0] <= issue;
            for (int i = 1; i < RAM_READ_LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            rd_addr_reg      <= '0;
            reads_left_reg   <= '0;
            seg_last_idx_reg <= '0;
            seg_pos_reg      <= '0;
            sent_reg         <= '0;
            lane_reg         <= '0;
            tdata_reg        <= '0;
            tvalid_reg       <= 1'b0;
            tlast_reg        <= 1'b0;
            final_reg        <= 1'b0;
        end else if (abort) begin
            reads_left_reg <= '0;
            lane_reg       <= '0;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
            final_reg      <= 1'b0;
        end else if (start_accept) begin
            rd_addr_reg      <= triggerAddress - pretriggerCount - AW'(TRIGGER_DETECTION_LATENCY);
            reads_left_reg   <= (AW+1)'(geom.seg_words * geom.seg_count);
            seg_last_idx_reg <= SCW'(geom.seg_words * SPC - 1);
            seg_pos_reg      <= '0;
            sent_reg         <= '0;
            lane_reg         <= '0;
        end else begin
            if (issue) begin
                rd_addr_reg    <= rd_addr_reg + 1'b1;
                reads_left_reg <= reads_left_reg - 1'b1;
            end
            if (load_sample) begin
                tdata_reg   <= sample_ext;
                tvalid_reg  <= 1'b1;
                tlast_reg   <= (seg_pos_reg == seg_last_idx_reg);
                final_reg   <= (sent_reg == SCW'(ACQUISITION_BUFFER_CAPACITY - 1));
                seg_pos_reg <= (seg_pos_reg == seg_last_idx_reg) ? '0 : seg_pos_reg + 1'b1;
                sent_reg    <= sent_reg + 1'b1;
                lane_reg    <= pop ? '0 : lane_reg + 1'b1;
            end
`ifdef ACQ_READOUT_TIMESTAMP_HEADER_EN
            else if (load_hdr) begin
                tdata_reg  <= hdr_chunk[hdr_cnt_reg[HIW-1:0]];
                tvalid_reg <= 1'b1;
                tlast_reg  <= 1'b0;
                final_reg  <= 1'b0;
            end
`endif
            else if (handshake) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
            end
        end
    end

    assign ramRdAddr = rd_addr_reg;
    assign m.tdata   = tdata_reg;
    assign m.tvalid  = tvalid_reg;
    assign m.tlast   = tlast_reg;
endmodule

// File: tb/tb_acquisition_readout.sv
// Scoreboard bench for acquisition_readout: random RAM contents, a latency-2 RAM model,
// an expected-beat queue built from the readout rules and a decoupled stream monitor.
module tb_acquisition_readout;
    localparam int CAP   = 2048;
    localparam int SPC   = 4;
    localparam int W     = 16;
    localparam int ADC   = 14;
    localparam int LONG  = 512;
    localparam int SHORT = 128;
    localparam int TDL   = 4;
    localparam int RRL   = 2;
    localparam int DEPTH = CAP / SPC;
    localparam int AW    = $clog2(DEPTH);
    localparam int LIMIT = 20000;
`ifdef ACQ_READOUT_TIMESTAMP_HEADER_EN
    localparam int HDR = 64 / W;
`else
    localparam int HDR = 0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic                 sysClk = 1'b0;
    logic                 sysReset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [1:0]           segMode = '0;
    logic [AW-1:0]        pretriggerCount = '0;
    logic [AW-1:0]        triggerAddress = '0;
    logic [63:0]          triggerTimestamp = '0;
    logic [AW-1:0]        ramRdAddr;
    logic [SPC*ADC-1:0]   ramRdData = '0;
    logic [SPC*ADC-1:0]   ram_pipe = '0;
    logic                 busy, done;

    logic [ADC-1:0] ram_samples [DEPTH*SPC];
    beat_t          exp_q [$];
    int total = 0, bad = 0;
    int hs_count = 0, last_count = 0, done_count = 0;
    int ready_pct = 100;

    acquisition_readout_if #(.DATA_WIDTH(W)) axis ();

    acquisition_readout #(
        .ACQUISITION_BUFFER_CAPACITY (CAP),
        .AXI_SAMPLES_PER_CLOCK       (SPC),
        .AXI_SAMPLE_WIDTH            (W),
        .ADC_WIDTH                   (ADC),
        .LONG_SEGMENT_CAPACITY       (LONG),
        .SHORT_SEGMENT_CAPACITY      (SHORT),
        .TRIGGER_DETECTION_LATENCY   (TDL),
        .RAM_READ_LATENCY            (RRL),
        .ADC_RAM_ADDRESS_WIDTH       (AW)
    ) dut (
        .sysClk           (sysClk),
        .sysReset_n       (sysReset_n),
        .start            (start),
        .abort            (abort),
        .segMode          (segMode),
        .pretriggerCount  (pretriggerCount),
        .triggerAddress   (triggerAddress),
        .triggerTimestamp (triggerTimestamp),
        .ramRdAddr        (ramRdAddr),
        .ramRdData        (ramRdData),
        .m                (axis),
        .busy             (busy),
        .done             (done)
    );

    always #5 sysClk = ~sysClk;

    function automatic logic [SPC*ADC-1:0] ram_word(input int w);
        logic [SPC*ADC-1:0] r;
        for (int i = 0; i < SPC; i++) r[i*ADC +: ADC] = ram_samples[w*SPC + i];
        return r;
    endfunction

    // Dual-port RAM read side: data appears two clocks after the address.
    always @(posedge sysClk) begin
        ram_pipe  <= ram_word(int'(ramRdAddr));
        ramRdData <= ram_pipe;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        axis.tready = 1'b0;
        forever begin
            @(posedge sysClk);
            #1 axis.tready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: pops one expected beat per handshake and checks AXI hold during stalls.
    initial begin
        beat_t e;
        logic         prev_stall = 1'b0;
        logic [W:0]   prev_beat = '0;
        forever begin
            @(negedge sysClk);
            if (sysReset_n) begin
                if (prev_stall && axis.tvalid)
                    check("hold_during_stall", {axis.tlast, axis.tdata}, prev_beat);
                if (axis.tvalid && axis.tready) begin
                    hs_count++;
                    if (axis.tlast) last_count++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat: got 0x%0h with no beat expected", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {axis.tlast, axis.tdata}, {e.last, e.data});
                    end
                end
                if (done) done_count++;
                prev_stall = axis.tvalid && !axis.tready;
                prev_beat  = {axis.tlast, axis.tdata};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    function automatic int seg_samples(input int mode);
        return (mode == 0) ? CAP : (mode == 1) ? LONG : SHORT;
    endfunction

    task automatic push_expected(input int mode, input int start_addr, input logic [63:0] ts);
        beat_t b;
        for (int h = 0; h < HDR; h++) begin
            b.data = ts[63 - h*W -: W];
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        for (int k = 0; k < CAP; k++) begin
            int w = (start_addr + k / SPC) % DEPTH;
            b.data = W'(ram_samples[w*SPC + k % SPC]) << (W - ADC);
            b.last = ((k + 1) % seg_samples(mode) == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic begin_run(input int mode, input int trig, input int pre, input logic [63:0] ts);
        int exp_start = (((trig - pre - TDL) % DEPTH) + DEPTH) % DEPTH;
        hs_count = 0;
        last_count = 0;
        done_count = 0;
        push_expected(mode, exp_start, ts);
        @(posedge sysClk);
        #1;
        segMode = 2'(mode);
        triggerAddress = AW'(trig);
        pretriggerCount = AW'(pre);
        triggerTimestamp = ts;
        start = 1'b1;
        @(posedge sysClk);
        #1;
        start = 1'b0;
        segMode = 2'($urandom);
        triggerAddress = AW'($urandom);
        pretriggerCount = AW'($urandom);
        triggerTimestamp = {$urandom, $urandom};
        @(negedge sysClk);
        check("first_rd_addr", ramRdAddr, exp_start);
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_run(input string name, input int mode);
        int c = 0;
        while (!done && c < LIMIT) begin
            @(negedge sysClk);
            c++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("beat_count", hs_count, CAP + HDR);
        check("tlast_count", last_count, CAP / seg_samples(mode));
        @(negedge sysClk);
        check("done_one_cycle", done, 0);
        $display("readout %s: mode=%0d beats=%0d tlast=%0d cycles=%0d", name, mode, hs_count, last_count, c);
        exp_q.delete();
    endtask

    task automatic wait_beats(input string name, input int n);
        int c = 0;
        while (hs_count < n && c < LIMIT) begin
            @(negedge sysClk);
            c++;
        end
        check(name, (hs_count >= n), 1);
    endtask

    initial begin
        int saved;
        for (int i = 0; i < DEPTH * SPC; i++) ram_samples[i] = ADC'($urandom);

        #12;
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdaddr", ramRdAddr, 0);
        @(posedge sysClk);
        #1 sysReset_n = 1'b1;

        ready_pct = 100;
        begin_run(0, 100, 50, 64'h0123_4567_89AB_CDEF);
        finish_run("continuous", 0);

        begin_run(2, 10, 0, {$urandom, $urandom});
        finish_run("short", 2);

        ready_pct = 30;
        begin_run(1, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), {$urandom, $urandom});
        finish_run("long_backpressure", 1);

        ready_pct = 70;
        begin_run(3, 2, 200, {$urandom, $urandom});
        finish_run("short_alt_wrap", 3);

        // start and abort together in IDLE: abort wins
        ready_pct = 100;
        saved = int'(ramRdAddr);
        @(posedge sysClk);
        #1 start = 1'b1;
        abort = 1'b1;
        @(posedge sysClk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge sysClk);
        check("start_abort_busy", busy, 0);
        repeat (5) @(negedge sysClk);
        check("start_abort_rdaddr", ramRdAddr, saved);
        check("start_abort_busy_late", busy, 0);

        begin_run(0, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), {$urandom, $urandom});
        wait_beats("reach_1000_beats", 1000);
        @(posedge sysClk);
        #1 abort = 1'b1;
        @(posedge sysClk);
        #1 abort = 1'b0;
        exp_q.delete();
        @(negedge sysClk);
        check("abort_tvalid", axis.tvalid, 0);
        check("abort_busy", busy, 0);
        saved = hs_count;
        repeat (50) @(negedge sysClk);
        check("abort_no_done", done_count, 0);
        check("abort_no_beats", hs_count, saved);
        $display("readout abort: beats before abort=%0d", saved);

        begin_run(2, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), {$urandom, $urandom});
        finish_run("after_abort", 2);

        begin_run(1, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), {$urandom, $urandom});
        wait_beats("reach_300_beats", 300);
        @(posedge sysClk);
        #1 segMode = 2'd0;
        triggerAddress = AW'($urandom);
        start = 1'b1;
        @(posedge sysClk);
        #1 start = 1'b0;
        finish_run("start_while_busy", 1);
        check("single_done", done_count, 1);

        begin_run(0, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), {$urandom, $urandom});
        wait_beats("reach_200_beats", 200);
        @(posedge sysClk);
        #2 sysReset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_tvalid", axis.tvalid, 0);
        check("async_rst_tlast", axis.tlast, 0);
        check("async_rst_tdata", axis.tdata, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_rdaddr", ramRdAddr, 0);
        $display("readout reset_mid_stream: beats before reset=%0d", hs_count);
        @(posedge sysClk);
        #1 sysReset_n = 1'b1;

        begin_run(1, 7, 3, 64'h0123_4567_89AB_CDEF);
        finish_run("after_reset", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
